camera_config_seq: RTL and testbench

CAMERA_CONFIG_SEQ -- requirements
Module: camera_config_seq

---
 rtl/camera_config_seq_if.sv | 24 ++
 rtl/camera_config_seq.sv | 108 ++++++++++
 tb/tb_camera_config_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/camera_config_seq_if.sv
// camera_config_seq_if: start/status, register-table and SCCB write bus of the camera config sequencer
//   master: sequencer side (drives o_*, samples i_*)
//   slave : environment side (table ROM, SCCB master, controller)
interface camera_config_seq_if;
    logic        i_Start;
    logic [7:0]  o_RomAddr;
    logic [15:0] i_RomData;
    logic        o_SccbStart;
    logic [7:0]  o_SccbId;
    logic [7:0]  o_SccbReg;
    logic [7:0]  o_SccbData;
    logic        i_SccbReady;
    logic        o_Busy;
    logic        o_Done;
    logic [7:0]  o_WriteCount;
    modport master (
        input  i_Start, i_RomData, i_SccbReady,
        output o_RomAddr, o_SccbStart, o_SccbId, o_SccbReg, o_SccbData, o_Busy, o_Done, o_WriteCount
    );
    modport slave (
        output i_Start, i_RomData, i_SccbReady,
        input  o_RomAddr, o_SccbStart, o_SccbId, o_SccbReg, o_SccbData, o_Busy, o_Done, o_WriteCount
    );
endinterface

// File: rtl/camera_config_seq.sv
// camera_config_seq: walks a {reg, value} table and issues SCCB writes to the camera
//   i_Clk, i_Rst : clock, synchronous active-high reset
//   bus          : i_Start / o_Busy / o_Done / o_WriteCount status, o_RomAddr / i_RomData table port,
//                  o_SccbStart / o_SccbId / o_SccbReg / o_SccbData / i_SccbReady write port
//   Table entry FFFF ends the run, FFF0 holds for DELAY_CYCLES clocks, anything else is a write.
module camera_config_seq #(
    parameter int unsigned DELAY_CYCLES = 2400000,
    parameter logic [7:0]  CAM_ID       = 8'h42
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    camera_config_seq_if.master        bus
);
    typedef enum logic [3:0] {IDLE, FETCH, DECODE, SEND, GUARD, WAIT_RDY, DELAY, NEXT, DONE} state_t;
    localparam logic [21:0] DELAY_LOAD = 22'(DELAY_CYCLES - 1);
    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        start_q, start_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [21:0] dcnt_q, dcnt_d;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        start_d = 1'b0;
        reg_d   = reg_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        wcnt_d  = wcnt_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            IDLE, DONE: if (bus.i_Start) begin
                addr_d  = '0;
                wcnt_d  = '0;
                done_d  = 1'b0;
                busy_d  = 1'b1;
                state_d = FETCH;
            end
            FETCH: state_d = DECODE;
            DECODE: if (bus.i_RomData == 16'hFFFF) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end else if (bus.i_RomData == 16'hFFF0) begin
                dcnt_d  = DELAY_LOAD;
                state_d = DELAY;
            end else begin
                reg_d   = bus.i_RomData[15:8];
                data_d  = bus.i_RomData[7:0];
                state_d = SEND;
            end
            SEND: if (bus.i_SccbReady) begin
                start_d = 1'b1;
                wcnt_d  = wcnt_q + {7'd0, wcnt_q != 8'hFF};
                state_d = GUARD;
            end
            // The pulse is on the wire here and ready has not dropped yet, so ready is not trusted.
            GUARD: state_d = WAIT_RDY;
            WAIT_RDY: state_d = bus.i_SccbReady ? NEXT : WAIT_RDY;
            DELAY: if (dcnt_q == '0) state_d = NEXT;
                   else dcnt_d = dcnt_q - 22'd1;
            NEXT: if (addr_q == 8'hFF) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                addr_d  = addr_q + 8'd1;
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            start_q <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wcnt_q  <= wcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end
    assign bus.o_RomAddr    = addr_q;
    assign bus.o_SccbStart  = start_q;
    assign bus.o_SccbId     = CAM_ID;
    assign bus.o_SccbReg    = reg_q;
    assign bus.o_SccbData   = data_q;
    assign bus.o_Busy       = busy_q;
    assign bus.o_Done       = done_q;
    assign bus.o_WriteCount = wcnt_q;
endmodule

// File: tb/tb_camera_config_seq.sv
// tb_camera_config_seq: randomized self-checking bench for camera_config_seq against a table-walk model
module tb_camera_config_seq;
    localparam int DLY = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic block = 1'b0;
    logic mdl_rdy;
    int   rcnt;
    int   rdy_lat = 3;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   bad_rdy = 0;
    logic [15:0] rom [256];
    logic [15:0] obs_q[$];
    int          obs_t[$];
    logic [15:0] exp_q[$];
    int          exp_cnt;
    int          exp_addr;
    camera_config_seq_if bus();
    camera_config_seq #(.DELAY_CYCLES(DLY), .CAM_ID(8'h42)) dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.i_RomData <= rom[bus.o_RomAddr];
    always @(posedge clk) begin
        if (rst) begin
            mdl_rdy <= 1'b1;
            rcnt    <= 0;
        end else if (bus.o_SccbStart && bus.i_SccbReady) begin
            mdl_rdy <= 1'b0;
            rcnt    <= rdy_lat;
        end else if (rcnt > 0) begin
            rcnt <= rcnt - 1;
            if (rcnt == 1) mdl_rdy <= 1'b1;
        end
    end
    assign bus.i_SccbReady = mdl_rdy & ~block;
    always @(negedge clk) begin
        if (!rst && bus.o_SccbStart) begin
            obs_q.push_back({bus.o_SccbReg, bus.o_SccbData});
            obs_t.push_back(cyc);
            if (!bus.i_SccbReady) bad_rdy++;
        end
    end
    function automatic void model();
        exp_q.delete();
        exp_cnt  = 0;
        exp_addr = 255;
        for (int i = 0; i < 256; i++) begin
            if (rom[i] == 16'hFFFF) begin
                exp_addr = i;
                break;
            end
            if (rom[i] != 16'hFFF0) begin
                exp_q.push_back(rom[i]);
                if (exp_cnt < 255) exp_cnt++;
            end
        end
    endfunction
    function automatic logic [15:0] rand_write();
        return 16'($urandom_range(0, 16'hFEFF));
    endfunction
    task automatic pulse_start();
        @(negedge clk) bus.i_Start = 1'b1;
        @(negedge clk) bus.i_Start = 1'b0;
    endtask
    task automatic wait_done(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.o_Done) begin
                to = 1'b0;
                break;
            end
        end
    endtask
    task automatic test_reset();
        rst = 1'b1;
        bus.i_Start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.o_RomAddr !== 8'd0) begin n_bad++; $display("FAIL reset_addr got %0h want 0", bus.o_RomAddr); end
        n_cmp++; if (bus.o_SccbStart !== 1'b0) begin n_bad++; $display("FAIL reset_start got %b want 0", bus.o_SccbStart); end
        n_cmp++; if ({bus.o_SccbReg, bus.o_SccbData} !== 16'h0) begin n_bad++; $display("FAIL reset_regdata got %h want 0000", {bus.o_SccbReg, bus.o_SccbData}); end
        n_cmp++; if ({bus.o_Busy, bus.o_Done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done got %b want 00", {bus.o_Busy, bus.o_Done}); end
        n_cmp++; if (bus.o_WriteCount !== 8'd0) begin n_bad++; $display("FAIL reset_wcnt got %0d want 0", bus.o_WriteCount); end
        n_cmp++; if (bus.o_SccbId !== 8'h42) begin n_bad++; $display("FAIL reset_id got %h want 42", bus.o_SccbId); end
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus.o_Busy, bus.o_Done, bus.o_SccbStart} !== 3'b000) begin n_bad++; $display("FAIL idle_hold got %b want 000", {bus.o_Busy, bus.o_Done, bus.o_SccbStart}); end
    endtask
    task automatic test_single_write();
        bit to;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFFF;
        rdy_lat = 3;
        obs_q.delete();
        pulse_start();
        n_cmp++; if ({bus.o_Busy, bus.o_Done} !== 2'b10) begin n_bad++; $display("FAIL single_busy got %b want 10", {bus.o_Busy, bus.o_Done}); end
        wait_done(200, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL single_timeout got timeout want done"); end
        n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL single_nwrites got %0d want 1", obs_q.size()); end
        n_cmp++; if (obs_q.size() > 0 && obs_q[0] !== 16'h1280) begin n_bad++; $display("FAIL single_regdata got %h want 1280", obs_q[0]); end
        n_cmp++; if (bus.o_SccbId !== 8'h42) begin n_bad++; $display("FAIL single_id got %h want 42", bus.o_SccbId); end
        n_cmp++; if (bus.o_WriteCount !== 8'd1) begin n_bad++; $display("FAIL single_wcnt got %0d want 1", bus.o_WriteCount); end
        n_cmp++; if ({bus.o_Busy, bus.o_Done} !== 2'b01) begin n_bad++; $display("FAIL single_done got %b want 01", {bus.o_Busy, bus.o_Done}); end
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.o_Done !== 1'b1 || obs_q.size() !== 1) begin n_bad++; $display("FAIL single_done_hold got done=%b n=%0d want done=1 n=1", bus.o_Done, obs_q.size()); end
    endtask
    task automatic test_delay();
        bit to;
        int g0, g1;
        g0 = 0;
        g1 = 0;
        rdy_lat = 3;
        rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'hFFFF;
        obs_q.delete(); obs_t.delete();
        pulse_start();
        wait_done(300, to);
        if (obs_t.size() == 2) g0 = obs_t[1] - obs_t[0];
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
        obs_q.delete(); obs_t.delete();
        pulse_start();
        wait_done(300, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL delay_timeout got timeout want done"); end
        if (obs_t.size() == 2) g1 = obs_t[1] - obs_t[0];
        // a delay entry costs its own NEXT, FETCH and DECODE plus DLY cycles in DELAY
        n_cmp++; if (g1 - g0 !== DLY + 3) begin n_bad++; $display("FAIL delay_gap got %0d want %0d", g1 - g0, DLY + 3); end
        n_cmp++; if (bus.o_WriteCount !== 8'd2) begin n_bad++; $display("FAIL delay_wcnt got %0d want 2", bus.o_WriteCount); end
        n_cmp++; if (obs_q.size() !== 2 || obs_q[1] !== 16'h1204) begin n_bad++; $display("FAIL delay_writes got n=%0d want n=2 last=1204", obs_q.size()); end
    endtask
    task automatic test_busy_master();
        bit to;
        rom[0] = 16'h3A04; rom[1] = 16'hFFFF;
        rdy_lat = 2;
        obs_q.delete();
        @(negedge clk) block = 1'b1;
        pulse_start();
        repeat (14) @(negedge clk);
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL busy_no_start got %0d pulses want 0", obs_q.size()); end
        n_cmp++; if (bus.o_Busy !== 1'b1) begin n_bad++; $display("FAIL busy_hold got %b want 1", bus.o_Busy); end
        block = 1'b0;
        wait_done(200, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL busy_timeout got timeout want done"); end
        n_cmp++; if (obs_q.size() !== 1 || obs_q[0] !== 16'h3A04) begin n_bad++; $display("FAIL busy_one_pulse got n=%0d want n=1 3a04", obs_q.size()); end
    endtask
    task automatic test_no_end_marker();
        bit to;
        int errs;
        errs = 0;
        for (int i = 0; i < 256; i++) rom[i] = rand_write();
        rdy_lat = 1;
        model();
        obs_q.delete();
        pulse_start();
        wait_done(8000, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL noend_timeout got timeout want done"); end
        n_cmp++; if (obs_q.size() !== 256) begin n_bad++; $display("FAIL noend_nwrites got %0d want 256", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) errs++;
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL noend_data got %0d bad writes want 0", errs); end
        n_cmp++; if (bus.o_WriteCount !== 8'd255) begin n_bad++; $display("FAIL noend_wcnt got %0d want 255", bus.o_WriteCount); end
        n_cmp++; if (bus.o_RomAddr !== 8'd255) begin n_bad++; $display("FAIL noend_addr got %0d want 255", bus.o_RomAddr); end
        n_cmp++; if (bus.o_Done !== 1'b1) begin n_bad++; $display("FAIL noend_done got %b want 1", bus.o_Done); end
    endtask
    task automatic test_reset_mid_run();
        bit to;
        int k;
        for (int i = 0; i < 10; i++) rom[i] = rand_write();
        rom[10] = 16'hFFFF;
        rdy_lat = 4;
        model();
        obs_q.delete();
        pulse_start();
        k = 0;
        while (obs_q.size() < 6 && k < 500) begin @(negedge clk); k++; end
        n_cmp++; if (obs_q.size() < 6) begin n_bad++; $display("FAIL rst_reach_entry5 got %0d writes want 6", obs_q.size()); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.o_RomAddr, bus.o_SccbReg, bus.o_SccbData, bus.o_WriteCount} !== 32'h0) begin n_bad++; $display("FAIL rst_mid_vals got %h want 00000000", {bus.o_RomAddr, bus.o_SccbReg, bus.o_SccbData, bus.o_WriteCount}); end
        n_cmp++; if ({bus.o_Busy, bus.o_Done, bus.o_SccbStart} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_flags got %b want 000", {bus.o_Busy, bus.o_Done, bus.o_SccbStart}); end
        rst = 1'b0;
        obs_q.delete();
        repeat (40) @(negedge clk);
        n_cmp++; if (obs_q.size() !== 0 || bus.o_Busy !== 1'b0) begin n_bad++; $display("FAIL rst_no_resume got n=%0d busy=%b want n=0 busy=0", obs_q.size(), bus.o_Busy); end
        pulse_start();
        n_cmp++; if (bus.o_RomAddr !== 8'd0) begin n_bad++; $display("FAIL rst_restart_addr got %0d want 0", bus.o_RomAddr); end
        wait_done(500, to);
        n_cmp++; if (to || obs_q.size() !== exp_q.size() || obs_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL rst_rerun got n=%0d to=%b want n=%0d", obs_q.size(), to, exp_q.size()); end
    endtask
    task automatic test_start_ignored();
        bit to;
        rom[0] = 16'h1100; rom[1] = 16'h6B4A; rom[2] = 16'h0C00; rom[3] = 16'hFFFF;
        rdy_lat = 6;
        model();
        obs_q.delete();
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (9) @(negedge clk);
        pulse_start();
        wait_done(500, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL ign_timeout got timeout want done"); end
        n_cmp++; if (obs_q.size() !== 3 || bus.o_WriteCount !== 8'd3) begin n_bad++; $display("FAIL ign_writes got n=%0d wcnt=%0d want 3/3", obs_q.size(), bus.o_WriteCount); end
        obs_q.delete();
        pulse_start();
        n_cmp++; if ({bus.o_Done, bus.o_Busy, bus.o_WriteCount} !== 10'b01_0000_0000) begin n_bad++; $display("FAIL restart_clear got done=%b busy=%b wcnt=%0d want 0/1/0", bus.o_Done, bus.o_Busy, bus.o_WriteCount); end
        wait_done(500, to);
        n_cmp++; if (to || obs_q.size() !== 3 || obs_q[2] !== 16'h0C00) begin n_bad++; $display("FAIL restart_rerun got n=%0d to=%b want n=3", obs_q.size(), to); end
    endtask
    task automatic test_random();
        bit to;
        int n, errs;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < 256; i++)
                rom[i] = (i >= n) ? 16'hFFFF : ($urandom_range(0, 7) == 0) ? 16'hFFF0 : rand_write();
            rdy_lat = $urandom_range(1, 6);
            model();
            obs_q.delete();
            pulse_start();
            wait_done(4000, to);
            errs = 0;
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) errs++;
            n_cmp++; if (to || obs_q.size() !== exp_q.size() || errs != 0) begin n_bad++; $display("FAIL rand%0d_writes got n=%0d bad=%0d to=%b want n=%0d", it, obs_q.size(), errs, to, exp_q.size()); end
            n_cmp++; if (bus.o_WriteCount !== 8'(exp_cnt) || bus.o_RomAddr !== 8'(exp_addr)) begin n_bad++; $display("FAIL rand%0d_state got wcnt=%0d addr=%0d want %0d/%0d", it, bus.o_WriteCount, bus.o_RomAddr, exp_cnt, exp_addr); end
        end
        n_cmp++; if (bad_rdy !== 0) begin n_bad++; $display("FAIL start_without_ready got %0d want 0", bad_rdy); end
    endtask
    initial begin
        bus.i_Start = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        test_reset();
        test_single_write();
        test_delay();
        test_busy_master();
        test_no_end_marker();
        test_reset_mid_run();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
